pci_initiator: RTL and testbench

//  Bus-master (initiator) end of the shared PCI bus, one instance per device A-D; counterpart to the arbiter.

---
 rtl/pci_pkg.sv | 27 ++
 rtl/pci_initiator_if.sv | 52 +++++
 rtl/pci_devsel_timer.sv | 37 +++
 rtl/pci_initiator.sv | 179 +++++++++++++++++
 tb/tb_pci_initiator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator: FSM states, command codes, idle bus values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pci_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_TURN = 3'd4
   } state_t;

   localparam logic [3:0]  CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0]  CMD_MEM_WRITE = 4'b0111;

   // Values driven when the initiator does not own the bus.
   localparam logic [3:0]  CBE_IDLE      = 4'hF;
   localparam logic [3:0]  CBE_ALL_BYTES = 4'h0;
   localparam logic [31:0] AD_IDLE       = 32'h0;

   // Odd-numbered PCI commands in the memory/IO groups are writes.
   function automatic logic is_write_cmd(input logic [3:0] c);
      return c[0];
   endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Local command + PCI bus signals of one initiator, grouped for a single port.
// Latency: n/a (wiring only).
// Backpressure: n/a; flow control lives in the gnt_n/trdy_n/devsel_n handshakes.
// Ports: master = initiator side (drives REQ#, FRAME#, IRDY#, AD, C/BE#, local status);
//        slave  = environment side (arbiter, target, local command source).
interface pci_initiator_if #(
   parameter int MAX_WORDS = 4
);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   // local command side
   logic             start;
   logic [3:0]       cmd;
   logic [31:0]      addr;
   logic [CNT_W-1:0] num_words;
   logic [31:0]      wdata;
   logic             wr_ack;
   logic [31:0]      rdata;
   logic             rd_valid;
   logic             busy;
   logic             done;
   logic             abort;
   // PCI bus side
   logic             req_n;
   logic             gnt_n;
   logic             frame_n_i;
   logic             irdy_n_i;
   logic             trdy_n;
   logic             devsel_n;
   logic [31:0]      ad_i;
   logic             frame_n_o;
   logic             irdy_n_o;
   logic             ctl_oe;
   logic [31:0]      ad_o;
   logic [3:0]       cbe_n_o;
   logic             ad_oe;

   modport master (
      input  start, cmd, addr, num_words, wdata,
      input  gnt_n, frame_n_i, irdy_n_i, trdy_n, devsel_n, ad_i,
      output wr_ack, rdata, rd_valid, busy, done, abort,
      output req_n, frame_n_o, irdy_n_o, ctl_oe, ad_o, cbe_n_o, ad_oe
   );

   modport slave (
      output start, cmd, addr, num_words, wdata,
      output gnt_n, frame_n_i, irdy_n_i, trdy_n, devsel_n, ad_i,
      input  wr_ack, rdata, rd_valid, busy, done, abort,
      input  req_n, frame_n_o, irdy_n_o, ctl_oe, ad_o, cbe_n_o, ad_oe
   );

endinterface

// File: rtl/pci_devsel_timer.sv
// DEVSEL# watchdog: flags master abort when no target claims the cycle in time.
// Latency: expired asserts TIMEOUT clocks of unclaimed data phase after load.
// Backpressure: none; counting pauses outside en, stops for good once DEVSEL# is seen.
// Ports: clk, rst (sync, active-high); load (initiator in address phase);
//        en (initiator in data phase); devsel_n (target claim); expired (abort now).
// Only instantiated when PCI_MASTER_ABORT_EN is defined.
module pci_devsel_timer #(
   parameter int TIMEOUT = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   input  logic devsel_n,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic          claimed_q;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt_q     <= '0;
         claimed_q <= 1'b0;
      end else if (en) begin
         if (!devsel_n) begin
            claimed_q <= 1'b1;
         end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign expired = ~claimed_q & (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: REQ#/GNT# arbitration, one address phase, 1..MAX_WORDS data phases, turnaround.
// Latency: 3+N clocks from sampled grant (bus idle) to done with TRDY# held low; +1 per wait state.
// Backpressure: waits on GNT# with idle bus; TRDY#=1 stalls a data phase with all outputs held.
// Ports: clk, rst (sync, active-high); bus (pci_initiator_if.master: local command/status + PCI pins).
// Build option PCI_MASTER_ABORT_EN: DEVSEL# timeout ends the burst with done+abort; otherwise abort=0.
module pci_initiator
   import pci_pkg::*;
#(
   parameter int MAX_WORDS      = 4,
   parameter int DEVSEL_TIMEOUT = 5
) (
   input  logic            clk,
   input  logic            rst,
   pci_initiator_if.master bus
);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   state_t           state_q, state_d;
   logic [3:0]       cmd_q;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] remaining_q;
   logic [31:0]      rdata_q;
   logic             rd_valid_q;
   logic             done_q;

   logic             is_write;
   logic             last_phase;
   logic             bus_idle;
   logic             xfer;
   logic             expired;

   logic             req_n_c, frame_n_c, irdy_n_c, ctl_oe_c, ad_oe_c;
   logic [31:0]      ad_o_c;
   logic [3:0]       cbe_n_c;

   assign is_write   = is_write_cmd(cmd_q);
   assign last_phase = (remaining_q == CNT_W'(1));
   assign bus_idle   = bus.frame_n_i & bus.irdy_n_i;
   // IRDY# is always low in DATA, so a transfer needs only target ready + claim.
   assign xfer       = (state_q == ST_DATA) & ~bus.trdy_n & ~bus.devsel_n & ~expired;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start)                  state_d = ST_REQ;
         ST_REQ:  if (!bus.gnt_n && bus_idle)     state_d = ST_ADDR;
         ST_ADDR:                                 state_d = ST_DATA;
         ST_DATA: if (expired || (xfer && last_phase)) state_d = ST_TURN;
         ST_TURN:                                 state_d = ST_IDLE;
         default:                                 state_d = ST_IDLE;
      endcase
   end

   // ---------------- burst bookkeeping ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q       <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         rdata_q     <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            ST_IDLE: if (bus.start) begin
               cmd_q       <= bus.cmd;
               addr_q      <= bus.addr;
               remaining_q <= (bus.num_words == '0) ? CNT_W'(1) : bus.num_words;
            end
            ST_DATA: if (xfer) begin
               remaining_q <= remaining_q - CNT_W'(1);
               if (!is_write) begin
                  rdata_q    <= bus.ad_i;
                  rd_valid_q <= 1'b1;
               end
            end
            // done lands in the first IDLE cycle, after the turnaround released the bus.
            ST_TURN: done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- bus outputs ----------------
   always_comb begin
      req_n_c   = 1'b1;
      frame_n_c = 1'b1;
      irdy_n_c  = 1'b1;
      ctl_oe_c  = 1'b0;
      ad_oe_c   = 1'b0;
      ad_o_c    = AD_IDLE;
      cbe_n_c   = CBE_IDLE;
      case (state_q)
         ST_REQ: req_n_c = 1'b0;
         ST_ADDR: begin
            frame_n_c = 1'b0;
            ctl_oe_c  = 1'b1;
            ad_oe_c   = 1'b1;
            ad_o_c    = addr_q;
            cbe_n_c   = cmd_q;
         end
         ST_DATA: begin
            // FRAME# goes high to mark the final phase (or a master abort).
            frame_n_c = last_phase | expired;
            irdy_n_c  = 1'b0;
            ctl_oe_c  = 1'b1;
            cbe_n_c   = CBE_ALL_BYTES;
            if (is_write) begin
               ad_oe_c = 1'b1;
               ad_o_c  = bus.wdata;
            end
         end
         // Drive FRAME#/IRDY# high for one clock before floating them.
         ST_TURN: ctl_oe_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.req_n     = req_n_c;
   assign bus.frame_n_o = frame_n_c;
   assign bus.irdy_n_o  = irdy_n_c;
   assign bus.ctl_oe    = ctl_oe_c;
   assign bus.ad_oe     = ad_oe_c;
   assign bus.ad_o      = ad_o_c;
   assign bus.cbe_n_o   = cbe_n_c;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.wr_ack    = xfer & is_write;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rdata     = rdata_q;

`ifdef PCI_MASTER_ABORT_EN
   logic timer_load, timer_en;
   logic abort_flag_q, abort_q;

   assign timer_load = (state_q == ST_ADDR);
   assign timer_en   = (state_q == ST_DATA);

   pci_devsel_timer #(
      .TIMEOUT (DEVSEL_TIMEOUT)
   ) u_devsel_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .en       (timer_en),
      .devsel_n (bus.devsel_n),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         abort_flag_q <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         if (state_q == ST_IDLE)                abort_flag_q <= 1'b0;
         else if (state_q == ST_DATA && expired) abort_flag_q <= 1'b1;
         if (state_q == ST_TURN)                abort_q      <= abort_flag_q;
      end
   end

   assign bus.abort = abort_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (DEVSEL_TIMEOUT > 0);
   assign expired   = 1'b0;
   assign bus.abort = 1'b0;
`endif

endmodule

// File: tb/tb_pci_initiator.sv
module tb_pci_initiator;

   logic clk;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;

   pci_initiator_if #(.MAX_WORDS(4)) bus ();

   pci_initiator #(
      .MAX_WORDS      (4),
      .DEVSEL_TIMEOUT (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0]      cmd;
      logic [31:0]     addr;
      int              n;
      int              g;      // idle-grant delay cycles in REQ
      int              bb;     // cycles the bus is busy (other master) while granted
      logic [3:0][1:0] w;      // wait states per data phase
      logic [31:0]     wbase;
      logic [31:0]     rbase;
      int              exp_done;
      int              exp_wr;
      int              exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_n"},    bus.req_n,     1'b1);
      chk({tag, "_frame"},    bus.frame_n_o, 1'b1);
      chk({tag, "_irdy"},     bus.irdy_n_o,  1'b1);
      chk({tag, "_ctl_oe"},   bus.ctl_oe,    1'b0);
      chk({tag, "_ad_oe"},    bus.ad_oe,     1'b0);
      chk({tag, "_ad_o"},     bus.ad_o,      32'h0);
      chk({tag, "_cbe"},      bus.cbe_n_o,   4'hF);
      chk({tag, "_busy"},     bus.busy,      1'b0);
      chk({tag, "_done"},     bus.done,      1'b0);
      chk({tag, "_abort"},    bus.abort,     1'b0);
      chk({tag, "_wr_ack"},   bus.wr_ack,    1'b0);
      chk({tag, "_rd_valid"}, bus.rd_valid,  1'b0);
      chk({tag, "_rdata"},    bus.rdata,     32'h0);
   endtask

   // Reference timeline of one burst, relative to the start cycle (c=0):
   // REQ from c=1; grant seen with idle bus at c=1+g+bb; ADDR one clock later;
   // each data phase k lasts w[k]+1 clocks, transferring on its last clock;
   // TURN one clock; done the clock after.
   task automatic run_burst(input logic [3:0] c_cmd, input logic [31:0] c_addr,
                            input int n_req, input int g, input int bb,
                            input logic [3:0][1:0] w,
                            input logic [31:0] wbase, input logic [31:0] rbase,
                            output int act_done, output int act_wr, output int act_rd);
      int n, t_addr, pc, t_turn;
      int ph[64];
      bit xf[64];
      bit is_wr, data, exp_rv;
      n      = (n_req == 0) ? 1 : n_req;
      is_wr  = (c_cmd == 4'b0111);
      t_addr = 2 + g + bb;
      pc     = t_addr + 1;
      for (int i = 0; i < 64; i++) begin
         ph[i] = -1;
         xf[i] = 1'b0;
      end
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j <= int'(w[k]); j++) begin
            ph[pc] = k;
            xf[pc] = (j == int'(w[k]));
            pc++;
         end
      end
      t_turn   = pc;
      act_done = -1;
      act_wr   = 0;
      act_rd   = 0;
      for (int c = 0; c <= t_turn + 1; c++) begin
         @(negedge clk);
         data = (ph[c] >= 0);
         // stray start pulses while busy must be ignored
         bus.start = (c == 0) || (c >= 1 && c <= t_turn && $urandom_range(0, 3) == 0);
         if (c == 0) begin
            bus.cmd       = c_cmd;
            bus.addr      = c_addr;
            bus.num_words = 3'(n_req);
         end else begin
            bus.cmd       = 4'($urandom);
            bus.addr      = $urandom;
            bus.num_words = 3'($urandom);
         end
         bus.gnt_n     = !(c >= 1 + g && c <= 1 + g + bb);
         bus.frame_n_i = !(c >= 1 + g && c < 1 + g + bb);
         bus.irdy_n_i  = 1'b1;
         bus.trdy_n    = !(data && xf[c]);
         bus.devsel_n  = !data;
         bus.wdata     = data ? wbase + 32'(ph[c]) : $urandom;
         bus.ad_i      = (data && xf[c]) ? rbase + 32'(ph[c]) : $urandom;
         #1;
         if (bus.done === 1'b1 && act_done < 0) act_done = c;
         if (bus.wr_ack === 1'b1) act_wr++;
         if (bus.rd_valid === 1'b1) act_rd++;

         chk("busy",   bus.busy,   (c >= 1 && c <= t_turn));
         chk("req_n",  bus.req_n,  !(c >= 1 && c <= 1 + g + bb));
         chk("done",   bus.done,   (c == t_turn + 1));
         chk("abort",  bus.abort,  1'b0);
         chk("wr_ack", bus.wr_ack, is_wr && data && xf[c]);
         chk("irdy_n_o", bus.irdy_n_o, !data);
         chk("ctl_oe", bus.ctl_oe, (c >= t_addr && c <= t_turn));
         chk("ad_oe",  bus.ad_oe,  (c == t_addr) || (data && is_wr));
         if (c == t_addr)   chk("frame_addr", bus.frame_n_o, 1'b0);
         else if (data)     chk("frame_data", bus.frame_n_o, (ph[c] == n - 1));
         else               chk("frame_idle", bus.frame_n_o, 1'b1);
         if (c == t_addr) begin
            chk("ad_addr",  bus.ad_o,    c_addr);
            chk("cbe_addr", bus.cbe_n_o, c_cmd);
         end else if (data) begin
            chk("cbe_data", bus.cbe_n_o, 4'h0);
            if (is_wr) chk("ad_wdata", bus.ad_o, wbase + 32'(ph[c]));
         end else if (c < t_addr || c == t_turn + 1) begin
            chk("cbe_idle", bus.cbe_n_o, 4'hF);
         end
         exp_rv = !is_wr && c > 0 && xf[c-1];
         chk("rd_valid", bus.rd_valid, exp_rv);
         if (exp_rv) chk("rdata", bus.rdata, rbase + 32'(ph[c-1]));
      end
      bus.start = 1'b0;
   endtask

   vec_t tbl[6];
   int   a_done, a_wr, a_rd;
   logic abort_seen;

   initial begin
      tbl[0] = '{4'b0111, 32'h100,      1, 0, 0, 8'h00, 32'hCAFE0000, 32'h0, 5, 1, 0};
      tbl[1] = '{4'b0110, 32'h2000,     4, 0, 0, 8'h00, 32'h0,        32'h1, 8, 0, 4};
      tbl[2] = '{4'b0111, 32'h3000,     2, 1, 0, 8'h02, 32'h55AA0000, 32'h0, 9, 2, 0};
      tbl[3] = '{4'b0110, 32'h4000,     0, 2, 0, 8'h01, 32'h0,  32'h77000000, 8, 0, 1};
      tbl[4] = '{4'b0111, 32'h5000,     3, 0, 0, 8'h04, 32'h12340000, 32'h0, 8, 3, 0};
      tbl[5] = '{4'b0110, 32'h6000,     1, 0, 3, 8'h00, 32'h0,  32'h9000_0000, 8, 0, 1};

      rst = 1'b1;
      bus.start = 1'b0; bus.cmd = 4'h0; bus.addr = 32'h0; bus.num_words = 3'd0;
      bus.wdata = 32'h0; bus.gnt_n = 1'b1; bus.frame_n_i = 1'b1; bus.irdy_n_i = 1'b1;
      bus.trdy_n = 1'b1; bus.devsel_n = 1'b1; bus.ad_i = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;

      // directed table
      for (int i = 0; i < 6; i++) begin
         run_burst(tbl[i].cmd, tbl[i].addr, tbl[i].n, tbl[i].g, tbl[i].bb, tbl[i].w,
                   tbl[i].wbase, tbl[i].rbase, a_done, a_wr, a_rd);
         chk("tbl_done_cycle", a_done, tbl[i].exp_done);
         chk("tbl_wr_count",   a_wr,   tbl[i].exp_wr);
         chk("tbl_rd_count",   a_rd,   tbl[i].exp_rd);
      end

      // randomized bursts
      for (int i = 0; i < 25; i++) begin
         logic [3:0] r_cmd;
         int r_n, r_eff;
         r_cmd = ($urandom_range(0, 1) == 1) ? 4'b0111 : 4'b0110;
         r_n   = $urandom_range(0, 4);
         r_eff = (r_n == 0) ? 1 : r_n;
         run_burst(r_cmd, $urandom, r_n, $urandom_range(0, 3), $urandom_range(0, 2),
                   8'($urandom), $urandom, $urandom, a_done, a_wr, a_rd);
         chk("rnd_words", (r_cmd == 4'b0111) ? a_wr : a_rd, r_eff);
      end

      // DEVSEL# never asserted
      a_done = -1; a_wr = 0; abort_seen = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         bus.start = (c == 0); bus.cmd = 4'b0111; bus.addr = 32'h200; bus.num_words = 3'd2;
         bus.gnt_n = !(c == 1); bus.frame_n_i = 1'b1; bus.irdy_n_i = 1'b1;
         bus.trdy_n = !(c >= 3); bus.devsel_n = 1'b1;
         bus.wdata = $urandom; bus.ad_i = $urandom;
         #1;
         if (bus.done === 1'b1 && a_done < 0) begin
            a_done = c;
            abort_seen = bus.abort;
         end
         if (bus.wr_ack === 1'b1) a_wr++;
      end
      chk("nodevsel_wr_ack", a_wr, 0);
`ifdef PCI_MASTER_ABORT_EN
      chk("abort_done_cycle", a_done, 10);
      chk("abort_flag", abort_seen, 1'b1);
`else
      chk("nodevsel_no_done", a_done, -1);
      chk("nodevsel_irdy",    bus.irdy_n_o, 1'b0);
      chk("nodevsel_busy",    bus.busy, 1'b1);
`endif
      @(negedge clk);
      rst = 1'b1; bus.start = 1'b0; bus.trdy_n = 1'b1; bus.gnt_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst1");

      // reset in the middle of a 4-word read, after 2 words
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         bus.start = (c == 0); bus.cmd = 4'b0110; bus.addr = 32'h300; bus.num_words = 3'd4;
         bus.gnt_n = !(c == 1);
         bus.trdy_n = !(c == 3 || c == 4);
         bus.devsel_n = !(c == 3 || c == 4);
         bus.ad_i = (c == 3) ? 32'hA0 : (c == 4) ? 32'hA1 : $urandom;
         rst = (c == 5);
         #1;
         if (c == 4) chk("mid_rdata0", bus.rdata, 32'hA0);
         if (c == 5) begin
            chk("mid_rdata1", bus.rdata, 32'hA1);
            chk("mid_busy", bus.busy, 1'b1);
         end
      end
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0; bus.trdy_n = 1'b1; bus.devsel_n = 1'b1; bus.gnt_n = 1'b1;
      #1;
      chk_reset_outputs("rst2");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("post_rst_done", bus.done, 1'b0);
         chk("post_rst_busy", bus.busy, 1'b0);
      end
      run_burst(4'b0110, 32'h400, 1, 0, 0, 8'h00, 32'h0, 32'hBEEF, a_done, a_wr, a_rd);
      chk("post_rst_burst_done", a_done, 5);
      chk("post_rst_burst_rd",   a_rd,   1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
